// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between NUM_REQ requesters.
// Grants one access per cycle, stalls the losers and steers read responses back by id.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RD_LAT  = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        fsm_stall,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IdW-1:0] id_t;

  localparam logic [IdW:0] NumReqW = (IdW+1)'(NUM_REQ);
  localparam id_t          LastId  = id_t'(NUM_REQ - 1);

  id_t                     rr_ptr_q, rr_ptr_d;
  id_t                     grant_id;
  logic                    any_grant;
  logic [IdW:0]            scan_idx;
  logic [RD_LAT-1:0]       tag_valid_q;
  id_t  [RD_LAT-1:0]       tag_id_q;

  // Scan from rr_ptr upward with explicit wrap so non-power-of-two NUM_REQ works.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    any_grant = 1'b0;
    scan_idx  = '0;
    if (!reset) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        scan_idx = {1'b0, rr_ptr_q} + (IdW+1)'(off);
        if (scan_idx >= NumReqW) begin
          scan_idx = scan_idx - NumReqW;
        end
        if (!any_grant && req_valid[scan_idx[IdW-1:0]]) begin
          any_grant = 1'b1;
          grant_id  = scan_idx[IdW-1:0];
        end
      end
    end
    if (any_grant) begin
      grant[grant_id] = 1'b1;
    end
  end

  assign fsm_stall = req_valid & ~grant;
  assign mem_en    = any_grant;

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_we    = req_we[i];
        mem_addr  = req_addr[i*ADDR_W +: ADDR_W];
        mem_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (grant_id == LastId) ? '0 : grant_id + id_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Tag pipeline: one {valid,id} entry per cycle, exits exactly when mem_rdata is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      tag_valid_q[0] <= mem_en & ~mem_we;
      tag_id_q[0]    <= grant_id;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_id_q[i]    <= tag_id_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (!reset && tag_valid_q[RD_LAT-1]) begin
      rsp_valid[tag_id_q[RD_LAT-1]] = 1'b1;
    end
  end

  assign rsp_data = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A (2 requesters, latency 2) and instance B (3 requesters,
// latency 3), each backed by a small behavioural memory.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: NUM_REQ=2, RD_LAT=2 ----------------
  logic        a_reset;
  logic [1:0]  a_req_valid, a_req_we, a_fsm_stall, a_grant, a_rsp_valid;
  logic [19:0] a_req_addr;
  logic [63:0] a_req_wdata;
  logic        a_mem_en, a_mem_we;
  logic [9:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_rdata, a_rsp_data;
  logic [31:0] mem_a [1024];
  logic [31:0] a_rd_pipe [2];

  mem_port_arbiter #(.NUM_REQ(2), .ADDR_W(10), .DATA_W(32), .RD_LAT(2)) dut_a (
    .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .fsm_stall(a_fsm_stall),
    .grant(a_grant), .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .rsp_valid(a_rsp_valid),
    .rsp_data(a_rsp_data)
  );

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    a_rd_pipe[0] <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr] : 32'h0;
    a_rd_pipe[1] <= a_rd_pipe[0];
  end
  assign a_mem_rdata = a_rd_pipe[1];

  // ---------------- instance B: NUM_REQ=3, RD_LAT=3 ----------------
  logic        b_reset;
  logic [2:0]  b_req_valid, b_req_we, b_fsm_stall, b_grant, b_rsp_valid;
  logic [29:0] b_req_addr;
  logic [95:0] b_req_wdata;
  logic        b_mem_en, b_mem_we;
  logic [9:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata, b_rsp_data;
  logic [31:0] b_rd_pipe [3];

  mem_port_arbiter #(.NUM_REQ(3), .ADDR_W(10), .DATA_W(32), .RD_LAT(3)) dut_b (
    .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .fsm_stall(b_fsm_stall),
    .grant(b_grant), .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .rsp_valid(b_rsp_valid),
    .rsp_data(b_rsp_data)
  );

  // Read-only memory for B: contents are a fixed function of the address.
  always @(posedge clk) begin
    b_rd_pipe[0] <= (b_mem_en && !b_mem_we) ? (32'hA500_0000 ^ {22'h0, b_mem_addr}) : 32'h0;
    b_rd_pipe[1] <= b_rd_pipe[0];
    b_rd_pipe[2] <= b_rd_pipe[1];
  end
  assign b_mem_rdata = b_rd_pipe[2];

  logic [9:0] a0, a1, iss;
  logic [9:0] b_addr [3];
  logic [9:0] exp_addr [1000];
  int wait_cnt [3];
  int max_wait [3];

  initial begin
    for (int i = 0; i < 1024; i++) mem_a[i] = 32'h1000_0000 + i;
    a_reset = 1'b1; a_req_valid = 2'b11; a_req_we = 2'b00;
    a_req_addr = '0; a_req_wdata = '0;
    b_reset = 1'b1; b_req_valid = 3'b000; b_req_we = 3'b000;
    b_req_addr = '0; b_req_wdata = '0;

    // 1: reset held 3 cycles with everyone requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_grant_rst", 64'(a_grant), 64'h0);
      chk("t1_mem_en_rst", 64'(a_mem_en), 64'h0);
      chk("t1_rsp_rst", 64'(a_rsp_valid), 64'h0);
    end

    // 2: both reading continuously; grants alternate from requester 0
    for (int k = 0; k < 10; k++) begin
      step();
      a_reset = 1'b0;
      a0 = 10'(10 + (k + 1) / 2);
      a1 = 10'(20 + k / 2);
      a_req_addr  = {a1, a0};
      a_req_valid = (k < 8) ? 2'b11 : 2'b00;
      @(negedge clk);
      if (k < 8) begin
        chk("t2_grant", 64'(a_grant), (k % 2 == 0) ? 64'h1 : 64'h2);
        chk("t2_stall", 64'(a_fsm_stall), (k % 2 == 0) ? 64'h2 : 64'h1);
        chk("t2_addr", 64'(a_mem_addr), (k % 2 == 0) ? 64'(a0) : 64'(a1));
      end else begin
        chk("t2_idle", 64'(a_grant), 64'h0);
      end
      if (k >= 2) begin
        iss = ((k - 2) % 2 == 0) ? 10'(10 + (k - 2) / 2) : 10'(20 + (k - 2) / 2);
        chk("t2_rsp_valid", 64'(a_rsp_valid), (k % 2 == 0) ? 64'h1 : 64'h2);
        chk("t2_rsp_data", 64'(a_rsp_data), 64'(32'h1000_0000 + iss));
      end else begin
        chk("t2_rsp_early", 64'(a_rsp_valid), 64'h0);
      end
    end

    // 3: only requester 1 for 5 cycles, then requester 0 joins and wins
    for (int k = 0; k < 5; k++) begin
      step();
      a_req_valid = 2'b10; a_req_addr = {10'd30, 10'd0};
      @(negedge clk);
      chk("t3_grant1", 64'(a_grant), 64'h2);
      chk("t3_nostall", 64'(a_fsm_stall), 64'h0);
    end
    step();
    a_req_valid = 2'b11; a_req_addr = {10'd30, 10'd40};
    @(negedge clk);
    chk("t3_wrap_grant", 64'(a_grant), 64'h1);
    chk("t3_wrap_stall", 64'(a_fsm_stall), 64'h2);
    for (int k = 0; k < 3; k++) begin
      step();
      a_req_valid = 2'b00;
    end
    @(negedge clk);
    chk("t3_drain_en", 64'(a_mem_en), 64'h0);

    // 4: req 0 writes, req 1 reads same address next cycle
    step();
    a_req_valid = 2'b01; a_req_we = 2'b01;
    a_req_addr = {10'd0, 10'd5}; a_req_wdata = {32'h0, 32'hDEAD_BEEF};
    @(negedge clk);
    chk("t4_wr_grant", 64'(a_grant), 64'h1);
    chk("t4_wr_we", 64'(a_mem_we), 64'h1);
    chk("t4_wr_addr", 64'(a_mem_addr), 64'h5);
    chk("t4_wr_data", 64'(a_mem_wdata), 64'hDEAD_BEEF);
    step();
    a_req_valid = 2'b10; a_req_we = 2'b00;
    a_req_addr = {10'd5, 10'd0}; a_req_wdata = '0;
    @(negedge clk);
    chk("t4_rd_grant", 64'(a_grant), 64'h2);
    chk("t4_rd_we", 64'(a_mem_we), 64'h0);
    step();
    a_req_valid = 2'b00;
    @(negedge clk);
    chk("t4_no_wr_rsp", 64'(a_rsp_valid), 64'h0);
    step();
    @(negedge clk);
    chk("t4_rsp_valid", 64'(a_rsp_valid), 64'h2);
    chk("t4_rsp_data", 64'(a_rsp_data), 64'hDEAD_BEEF);

    // 5: read issued, reset pulsed next cycle drops it and clears rr_ptr
    step();
    a_req_valid = 2'b01; a_req_addr = {10'd0, 10'd7};
    @(negedge clk);
    chk("t5_issue", 64'(a_grant), 64'h1);
    step();
    a_reset = 1'b1; a_req_valid = 2'b00;
    @(negedge clk);
    chk("t5_rsp_in_rst", 64'(a_rsp_valid), 64'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      a_reset = 1'b0;
      @(negedge clk);
      chk("t5_rsp_dropped", 64'(a_rsp_valid), 64'h0);
    end
    step();
    a_req_valid = 2'b11;
    @(negedge clk);
    chk("t5_ptr_zero", 64'(a_grant), 64'h1);
    step();
    a_req_valid = 2'b00;

    // 6: three requesters reading random addresses for 1000 cycles
    for (int i = 0; i < 3; i++) begin
      b_addr[i] = 10'($urandom_range(0, 1023));
      wait_cnt[i] = 0;
      max_wait[i] = 0;
    end
    for (int k = 0; k < 1004; k++) begin
      step();
      b_reset = 1'b0;
      if (k > 0 && k <= 1000) b_addr[(k - 1) % 3] = 10'($urandom_range(0, 1023));
      b_req_addr  = {b_addr[2], b_addr[1], b_addr[0]};
      b_req_valid = (k < 1000) ? 3'b111 : 3'b000;
      if (k < 1000) exp_addr[k] = b_addr[k % 3];
      @(negedge clk);
      if (k < 1000) begin
        chk("t6_grant", 64'(b_grant), 64'(1) << (k % 3));
        chk("t6_stall", 64'(b_fsm_stall), 64'(3'b111 & ~(3'b001 << (k % 3))));
        chk("t6_addr", 64'(b_mem_addr), 64'(exp_addr[k]));
        for (int i = 0; i < 3; i++) begin
          wait_cnt[i] = b_fsm_stall[i] ? wait_cnt[i] + 1 : 0;
          if (wait_cnt[i] > max_wait[i]) max_wait[i] = wait_cnt[i];
        end
      end else begin
        chk("t6_idle", 64'(b_grant), 64'h0);
      end
      if (k >= 3 && k < 1003) begin
        chk("t6_rsp_valid", 64'(b_rsp_valid), 64'(1) << ((k - 3) % 3));
        chk("t6_rsp_data", 64'(b_rsp_data), 64'(32'hA500_0000 ^ {22'h0, exp_addr[k - 3]}));
      end else begin
        chk("t6_rsp_none", 64'(b_rsp_valid), 64'h0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk("t6_max_wait_le2", 64'(max_wait[i] <= 2), 64'h1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
